// File: rtl/semaforo_planificador.sv
// semaforo_planificador: phase scheduler for a two-street intersection.
// Street A rests on green; street B and the pedestrian walk phase are served
// on demand from latched requests, each phase timed by a down-counter.
// Optional night flashing mode: define SEMAFORO_INTERMITENTE_EN to add the
// i_modo_noche input and the FLASH state.
//
// state        | meaning
// -------------+------------------------------------------------------------
// A_VERDE    0 | A green, B red; holds past its minimum until a request exists
// A_AMARILLO 1 | A yellow, B red
// TODO_ROJO  2 | all-red clearance; picks walk phase or green of siguiente
// B_VERDE    3 | B green for exactly T_VERDE, A red
// B_AMARILLO 4 | B yellow, A red
// PEATONAL   5 | both lights red, walk outputs follow the served mask
// FLASH      6 | night mode: both lights blink yellow/off (macro only)

module semaforo_planificador #(
    parameter int CW          = 4,
    parameter int T_VERDE     = 8,
    parameter int T_AMARILLO  = 2,
    parameter int T_TODO_ROJO = 1,
    parameter int T_PEATON    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enb,
    input  logic       i_req_a_peatonal,
    input  logic       i_req_b_peatonal,
    input  logic       i_sensor_b,
`ifdef SEMAFORO_INTERMITENTE_EN
    input  logic       i_modo_noche,
`endif
    output logic [1:0] o_semaforo_a,
    output logic [1:0] o_semaforo_b,
    output logic       o_a_peatonal,
    output logic       o_b_peatonal,
    output logic [2:0] o_fase,
    output logic [2:0] o_pendiente
);

    typedef enum logic [2:0] {
        S_A_VERDE    = 3'd0,
        S_A_AMARILLO = 3'd1,
        S_TODO_ROJO  = 3'd2,
        S_B_VERDE    = 3'd3,
        S_B_AMARILLO = 3'd4,
        S_PEATONAL   = 3'd5
`ifdef SEMAFORO_INTERMITENTE_EN
        , S_FLASH    = 3'd6
`endif
    } estado_t;

    localparam logic [1:0] LUZ_ROJO     = 2'b00;
    localparam logic [1:0] LUZ_AMARILLO = 2'b01;
    localparam logic [1:0] LUZ_VERDE    = 2'b10;
`ifdef SEMAFORO_INTERMITENTE_EN
    localparam logic [1:0] LUZ_APAGADO  = 2'b11;
`endif

    // Timer reload values: a state lasts exactly "duration" enabled cycles.
    localparam logic [CW-1:0] L_VERDE     = CW'(T_VERDE - 1);
    localparam logic [CW-1:0] L_AMARILLO  = CW'(T_AMARILLO - 1);
    localparam logic [CW-1:0] L_TODO_ROJO = CW'(T_TODO_ROJO - 1);
    localparam logic [CW-1:0] L_PEATON    = CW'(T_PEATON - 1);

    // Pending request bit positions in {veh_B, ped_B, ped_A}.
    localparam int P_PED_A = 0;
    localparam int P_PED_B = 1;
    localparam int P_VEH_B = 2;

    estado_t         r_estado;
    logic [CW-1:0]   r_timer;
    logic            r_sig_b;      // 0: next green is A, 1: next green is B
    logic [2:0]      r_pend;
    logic [1:0]      r_servida;    // {ped_B, ped_A} served in current walk phase
    logic [1:0]      r_sem_a;
    logic [1:0]      r_sem_b;
    logic            r_a_peat;
    logic            r_b_peat;
`ifdef SEMAFORO_INTERMITENTE_EN
    logic            r_flash_apagado;
    logic            w_flash_n;
`endif

    estado_t         w_estado_n;
    logic [CW-1:0]   w_timer_n;
    logic            w_sig_b_n;
    logic [2:0]      w_clr;
    logic [2:0]      w_pend_n;
    logic [1:0]      w_servida_n;
    logic [1:0]      w_sem_a_n;
    logic [1:0]      w_sem_b_n;
    logic [1:0]      w_walk_n;

    // Next-state, timer, routing and request-clear decisions.
    always_comb begin
        w_estado_n  = r_estado;
        w_timer_n   = r_timer;
        w_sig_b_n   = r_sig_b;
        w_servida_n = r_servida;
        w_clr       = 3'b000;
`ifdef SEMAFORO_INTERMITENTE_EN
        w_flash_n   = r_flash_apagado;
`endif
        if (i_enb) begin
            if (r_timer != '0) begin
                w_timer_n = r_timer - 1'b1;
            end else begin
                case (r_estado)
                    S_A_VERDE: begin
                        // Minimum green reached: leave only when someone waits.
                        if (r_pend != 3'b000) begin
                            w_estado_n = S_A_AMARILLO;
                            w_timer_n  = L_AMARILLO;
                        end
                    end
                    S_A_AMARILLO: begin
                        w_estado_n = S_TODO_ROJO;
                        w_sig_b_n  = 1'b1;
                        w_timer_n  = L_TODO_ROJO;
                    end
                    S_TODO_ROJO: begin
                        if (r_pend[P_PED_B:P_PED_A] != 2'b00) begin
                            w_estado_n  = S_PEATONAL;
                            w_timer_n   = L_PEATON;
                            w_servida_n = r_pend[P_PED_B:P_PED_A];
                            w_clr[P_PED_B:P_PED_A] = 2'b11;
                        end else if (r_sig_b) begin
                            w_estado_n     = S_B_VERDE;
                            w_timer_n      = L_VERDE;
                            w_clr[P_VEH_B] = 1'b1;
                        end else begin
                            w_estado_n = S_A_VERDE;
                            w_timer_n  = L_VERDE;
                        end
                    end
                    S_B_VERDE: begin
                        w_estado_n = S_B_AMARILLO;
                        w_timer_n  = L_AMARILLO;
                    end
                    S_B_AMARILLO: begin
                        w_estado_n = S_TODO_ROJO;
                        w_sig_b_n  = 1'b0;
                        w_timer_n  = L_TODO_ROJO;
                    end
                    S_PEATONAL: begin
                        // Walk phase already provides clearance: go straight to green.
                        w_servida_n = 2'b00;
                        w_timer_n   = L_VERDE;
                        if (r_sig_b) begin
                            w_estado_n     = S_B_VERDE;
                            w_clr[P_VEH_B] = 1'b1;
                        end else begin
                            w_estado_n = S_A_VERDE;
                        end
                    end
                    default: begin
                        w_estado_n = S_TODO_ROJO;
                        w_sig_b_n  = 1'b0;
                        w_timer_n  = L_TODO_ROJO;
                    end
                endcase
            end
        end
`ifdef SEMAFORO_INTERMITENTE_EN
        // Night mode overrides normal sequencing from any state.
        if (i_enb && i_modo_noche) begin
            w_clr       = 3'b000;
            w_servida_n = 2'b00;
            w_estado_n  = S_FLASH;
            if (r_estado != S_FLASH) begin
                w_timer_n = L_AMARILLO;
                w_flash_n = 1'b0;
            end else if (r_timer == '0) begin
                w_timer_n = L_AMARILLO;
                w_flash_n = ~r_flash_apagado;
            end else begin
                w_timer_n = r_timer - 1'b1;
            end
        end else if (i_enb && (r_estado == S_FLASH)) begin
            w_clr       = 3'b000;
            w_servida_n = 2'b00;
            w_estado_n  = S_TODO_ROJO;
            w_sig_b_n   = 1'b0;
            w_timer_n   = L_TODO_ROJO;
            w_flash_n   = 1'b0;
        end
`endif
    end

    // Request latching runs every clock, regardless of the advance enable.
    always_comb begin
        w_pend_n = (r_pend & ~w_clr) | {i_sensor_b, i_req_b_peatonal, i_req_a_peatonal};
`ifdef SEMAFORO_INTERMITENTE_EN
        if ((w_estado_n == S_FLASH) || (r_estado == S_FLASH)) begin
            w_pend_n = 3'b000;
        end
`endif
    end

    // Moore decode of the next state so the light outputs can be registered.
    always_comb begin
        w_sem_a_n = LUZ_ROJO;
        w_sem_b_n = LUZ_ROJO;
        w_walk_n  = 2'b00;
        case (w_estado_n)
            S_A_VERDE:    w_sem_a_n = LUZ_VERDE;
            S_A_AMARILLO: w_sem_a_n = LUZ_AMARILLO;
            S_B_VERDE:    w_sem_b_n = LUZ_VERDE;
            S_B_AMARILLO: w_sem_b_n = LUZ_AMARILLO;
            S_PEATONAL:   w_walk_n  = w_servida_n;
`ifdef SEMAFORO_INTERMITENTE_EN
            S_FLASH: begin
                w_sem_a_n = w_flash_n ? LUZ_APAGADO : LUZ_AMARILLO;
                w_sem_b_n = w_flash_n ? LUZ_APAGADO : LUZ_AMARILLO;
            end
`endif
            default: ;
        endcase
    end

    // State, timer, request and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_estado  <= S_TODO_ROJO;
            r_timer   <= L_TODO_ROJO;
            r_sig_b   <= 1'b0;
            r_pend    <= 3'b000;
            r_servida <= 2'b00;
            r_sem_a   <= LUZ_ROJO;
            r_sem_b   <= LUZ_ROJO;
            r_a_peat  <= 1'b0;
            r_b_peat  <= 1'b0;
`ifdef SEMAFORO_INTERMITENTE_EN
            r_flash_apagado <= 1'b0;
`endif
        end else begin
            r_estado  <= w_estado_n;
            r_timer   <= w_timer_n;
            r_sig_b   <= w_sig_b_n;
            r_pend    <= w_pend_n;
            r_servida <= w_servida_n;
            r_sem_a   <= w_sem_a_n;
            r_sem_b   <= w_sem_b_n;
            r_a_peat  <= w_walk_n[0];
            r_b_peat  <= w_walk_n[1];
`ifdef SEMAFORO_INTERMITENTE_EN
            r_flash_apagado <= w_flash_n;
`endif
        end
    end

    assign o_semaforo_a = r_sem_a;
    assign o_semaforo_b = r_sem_b;
    assign o_a_peatonal = r_a_peat;
    assign o_b_peatonal = r_b_peat;
    assign o_fase       = r_estado;
    assign o_pendiente  = r_pend;

endmodule

// File: tb/tb_semaforo_planificador.sv
// Directed bench for semaforo_planificador with default parameters
// (T_VERDE=8, T_AMARILLO=2, T_TODO_ROJO=1, T_PEATON=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.

module tb_semaforo_planificador;

    logic       clk = 1'b0;
    logic       rst, enb, req_a, req_b, sensor;
    logic [1:0] sem_a, sem_b;
    logic       a_p, b_p;
    logic [2:0] fase, pend;
`ifdef SEMAFORO_INTERMITENTE_EN
    logic       modo;
`endif

    int    n_checks = 0;
    int    n_errors = 0;
    string paso = "init";

    always #5 clk = ~clk;

    semaforo_planificador dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_enb            (enb),
        .i_req_a_peatonal (req_a),
        .i_req_b_peatonal (req_b),
        .i_sensor_b       (sensor),
`ifdef SEMAFORO_INTERMITENTE_EN
        .i_modo_noche     (modo),
`endif
        .o_semaforo_a     (sem_a),
        .o_semaforo_b     (sem_b),
        .o_a_peatonal     (a_p),
        .o_b_peatonal     (b_p),
        .o_fase           (fase),
        .o_pendiente      (pend)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One check per cycle of {fase, light A, light B, walk A, walk B}.
    task automatic hold(input logic [2:0] f, input logic [1:0] a, input logic [1:0] b,
                        input logic wa, input logic wb, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s fase%0d #%0d", paso, f, i),
                {fase, sem_a, sem_b, a_p, b_p}, {f, a, b, wa, wb});
            tick(1);
        end
    endtask

    task automatic chk_pend(input logic [2:0] exp);
        chk($sformatf("%s pend", paso), {6'b0, pend}, {6'b0, exp});
    endtask

    task automatic h_av(input int n); hold(3'd0, 2'b10, 2'b00, 1'b0, 1'b0, n); endtask
    task automatic h_aa(input int n); hold(3'd1, 2'b01, 2'b00, 1'b0, 1'b0, n); endtask
    task automatic h_tr(input int n); hold(3'd2, 2'b00, 2'b00, 1'b0, 1'b0, n); endtask
    task automatic h_bv(input int n); hold(3'd3, 2'b00, 2'b10, 1'b0, 1'b0, n); endtask
    task automatic h_ba(input int n); hold(3'd4, 2'b00, 2'b01, 1'b0, 1'b0, n); endtask
    task automatic h_pe(input logic wa, input logic wb, input int n);
        hold(3'd5, 2'b00, 2'b00, wa, wb, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; req_a = 1'b0; req_b = 1'b0; sensor = 1'b0;
`ifdef SEMAFORO_INTERMITENTE_EN
        modo = 1'b0;
`endif
        tick(2);
        rst = 1'b0;

        // Idle: one all-red cycle, then A rests on green.
        paso = "reset";
        chk_pend(3'b000);
        h_tr(1);
        h_av(50);
        chk_pend(3'b000);

        // Vehicle on B arrives mid A-green: full A->B->A rotation.
        paso = "sensor_b";
        do_reset();
        h_tr(1);
        h_av(2);
        sensor = 1'b1;
        h_av(1);
        sensor = 1'b0;
        chk_pend(3'b100);
        h_av(5);
        h_aa(2);
        chk_pend(3'b100);
        h_tr(1);
        chk_pend(3'b000);
        h_bv(8);
        h_ba(2);
        h_tr(1);
        h_av(8);

        // Ped A request while A green is parked at timer 0.
        paso = "ped_a";
        req_a = 1'b1;
        h_av(1);
        req_a = 1'b0;
        chk_pend(3'b001);
        h_av(1);
        h_aa(2);
        h_tr(1);
        chk_pend(3'b000);
        h_pe(1'b1, 1'b0, 4);
        h_bv(8);
        h_ba(2);
        h_tr(1);

        // Both peds; A re-pressed during walk; A pressed on the clearing edge.
        paso = "ped_ab";
        req_a = 1'b1; req_b = 1'b1;
        h_av(1);
        req_a = 1'b0; req_b = 1'b0;
        chk_pend(3'b011);
        h_av(7);
        h_aa(2);
        h_tr(1);
        h_pe(1'b1, 1'b1, 1);
        req_a = 1'b1;
        h_pe(1'b1, 1'b1, 1);
        req_a = 1'b0;
        chk_pend(3'b001);
        h_pe(1'b1, 1'b1, 2);
        h_bv(8);
        chk_pend(3'b001);
        h_ba(2);
        req_a = 1'b1;
        h_tr(1);
        req_a = 1'b0;
        chk_pend(3'b001);
        h_pe(1'b1, 1'b0, 4);
        h_av(8);
        h_aa(2);
        h_tr(1);
        chk_pend(3'b000);
        h_pe(1'b1, 1'b0, 4);
        h_bv(8);
        h_ba(2);
        h_tr(1);
        h_av(1);

        // ENB low freezes B green; requests still latch meanwhile.
        paso = "enb_freeze";
        do_reset();
        h_tr(1);
        sensor = 1'b1;
        h_av(1);
        sensor = 1'b0;
        h_av(7);
        h_aa(2);
        h_tr(1);
        h_bv(3);
        enb = 1'b0;
        h_bv(2);
        req_b = 1'b1;
        h_bv(1);
        req_b = 1'b0;
        chk_pend(3'b010);
        h_bv(2);
        enb = 1'b1;
        h_bv(5);
        h_ba(2);
        h_tr(1);
        h_pe(1'b0, 1'b1, 4);
        h_av(1);

        // Reset in the middle of a walk phase wins over a same-cycle request.
        paso = "rst_peat";
        req_a = 1'b1;
        h_av(1);
        req_a = 1'b0;
        h_av(6);
        h_aa(2);
        h_tr(1);
        h_pe(1'b1, 1'b0, 1);
        rst = 1'b1; req_b = 1'b1;
        tick(1);
        rst = 1'b0; req_b = 1'b0;
        chk_pend(3'b000);
        h_tr(1);
        h_av(8);
        chk_pend(3'b000);

`ifdef SEMAFORO_INTERMITENTE_EN
        // Night mode: yellow/off blinking, requests ignored, exit via all-red.
        paso = "noche";
        modo = 1'b1;
        h_av(1);
        hold(3'd6, 2'b01, 2'b01, 1'b0, 1'b0, 2);
        req_a = 1'b1; sensor = 1'b1;
        hold(3'd6, 2'b11, 2'b11, 1'b0, 1'b0, 2);
        req_a = 1'b0; sensor = 1'b0;
        chk_pend(3'b000);
        hold(3'd6, 2'b01, 2'b01, 1'b0, 1'b0, 2);
        modo = 1'b0;
        hold(3'd6, 2'b11, 2'b11, 1'b0, 1'b0, 1);
        h_tr(1);
        h_av(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
